// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - opcode constants, field positions and decode record for the hazard scoreboard
package hazard_scoreboard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [2:0] OP_IALU_PREFIX = 3'b001;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic       reads_rs;
    logic       reads_rt;
    logic       has_dest;
    logic [4:0] dest;
    logic       is_load;
  } decode_t;

  function automatic decode_t make_decode(input logic rrs, input logic rrt,
                                          input logic [4:0] dst, input logic ld);
    decode_t d;
    d.reads_rs = rrs;
    d.reads_rt = rrt;
    d.has_dest = (dst != REG_ZERO);
    d.dest     = dst;
    d.is_load  = ld;
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_decode.sv
// rtl/hazard_scoreboard_decode.sv - hazard_decode: opcode to source-use / destination classifier
module hazard_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [31:0] ins,
  output logic        reads_rs,
  output logic        reads_rt,
  output logic        has_dest,
  output logic [4:0]  dest,
  output logic        is_load
);

  logic [5:0] op;
  logic [4:0] rt;
  logic [4:0] rd;
  decode_t    d;
  logic       unused_ins_bits;

  assign op = ins[OP_HI:OP_LO];
  assign rt = ins[RT_HI:RT_LO];
  assign rd = ins[RD_HI:RD_LO];
  assign unused_ins_bits = ^{ins[RS_HI:RS_LO], ins[10:0]};

  // Unknown opcodes read both sources and write nothing, so they can only stall, never corrupt.
  always_comb begin
    d = make_decode(1'b1, 1'b1, REG_ZERO, 1'b0);
    if (op[5:3] == OP_IALU_PREFIX) begin
      d = make_decode(1'b1, 1'b0, rt, 1'b0);
    end else begin
      case (op)
        OP_RTYPE:       d = make_decode(1'b1, 1'b1, rd, 1'b0);
        OP_LW:          d = make_decode(1'b1, 1'b0, rt, 1'b1);
        OP_SW:          d = make_decode(1'b1, 1'b1, REG_ZERO, 1'b0);
        OP_BEQ, OP_BNE: d = make_decode(1'b1, 1'b1, REG_ZERO, 1'b0);
        OP_J:           d = make_decode(1'b0, 1'b0, REG_ZERO, 1'b0);
        OP_JAL:         d = make_decode(1'b0, 1'b0, REG_RA, 1'b0);
        default:        d = make_decode(1'b1, 1'b1, REG_ZERO, 1'b0);
      endcase
    end
  end

  assign reads_rs = d.reads_rs;
  assign reads_rt = d.reads_rt;
  assign has_dest = d.has_dest;
  assign dest     = d.dest;
  assign is_load  = d.is_load;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard driving ID stall and bypass selects
// Optional counters stall_cycles/fwd_events are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int CW       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_ins,
  input  logic        flush,
  output logic        stall,
  output logic        choose1,
  output logic        choose2,
  output logic        issued
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] fwd_events
`endif
);

  localparam logic [CW-1:0] ZERO  = '0;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] TWO   = CW'(2);
  localparam logic [CW-1:0] ALU_L = CW'(ALU_LAT);
  localparam logic [CW-1:0] LD_L  = CW'(LOAD_LAT);

  logic [CW-1:0] cnt [32];

  logic          reads_rs;
  logic          reads_rt;
  logic          has_dest;
  logic [4:0]    dest;
  logic          is_load;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [CW-1:0] lat;
  logic [CW-1:0] cnt_rs;
  logic [CW-1:0] cnt_rt;
  logic [CW-1:0] cnt_dest;
  logic          use_rs;
  logic          use_rt;
  logic          raw_rs;
  logic          raw_rt;
  logic          waw;

  hazard_decode u_decode (
    .ins      (id_ins),
    .reads_rs (reads_rs),
    .reads_rt (reads_rt),
    .has_dest (has_dest),
    .dest     (dest),
    .is_load  (is_load)
  );

  assign rs       = id_ins[RS_HI:RS_LO];
  assign rt       = id_ins[RT_HI:RT_LO];
  assign lat      = is_load ? LD_L : ALU_L;
  assign cnt_rs   = cnt[rs];
  assign cnt_rt   = cnt[rt];
  assign cnt_dest = cnt[dest];

  assign use_rs = id_valid && reads_rs && (rs != REG_ZERO);
  assign use_rt = id_valid && reads_rt && (rt != REG_ZERO);

  assign raw_rs = use_rs && (cnt_rs >= TWO);
  assign raw_rt = use_rt && (cnt_rt >= TWO);
  // An older write still landing after ours would overwrite the newer value.
  assign waw    = id_valid && has_dest && (cnt_dest > lat);

  assign stall   = raw_rs || raw_rt || waw;
  assign choose1 = use_rs && (cnt_rs == ONE);
  assign choose2 = use_rt && (cnt_rt == ONE);
  assign issued  = id_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt[r] <= ZERO;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (r == 0) begin
          cnt[r] <= ZERO;
        end else if (issued && has_dest && (dest == 5'(r))) begin
          cnt[r] <= lat;
        end else if (cnt[r] != ZERO) begin
          cnt[r] <= cnt[r] - ONE;
        end
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (issued && (choose1 || choose2) && (fwd_events != 32'hFFFF_FFFF)) begin
        fwd_events <= fwd_events + 32'd1;
      end
    end
  end
`endif

endmodule
